flap_game_sequencer: RTL and testbench

FLAP_GAME_SEQUENCER -- requirements
Module: flap_game_sequencer

---
 rtl/flap_game_pkg.sv | 25 ++
 rtl/rise_detect.sv | 37 +++
 rtl/flap_game_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_flap_game_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flap_game_pkg.sv
// Shared definitions for the flap game sequencer: state encoding,
// default timing constants and a small helper.
package flap_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DYING = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam int unsigned DEF_READY_FRAMES     = 60;
    localparam int unsigned DEF_DIE_FRAMES       = 30;
    localparam int unsigned DEF_OVER_FRAMES      = 600;
    localparam bit          DEF_VSYNC_ACTIVE_LOW = 1'b1;

    // Frame counter width; comfortably covers the longest phase.
    localparam int unsigned FRAME_CNT_W = 16;

    function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with one history flop. The edge is offered either
// combinationally (same cycle as the input rise) or through a pulse flop
// (one cycle later), selected by REGISTERED_OUT.
module rise_detect #(
    parameter bit REGISTERED_OUT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev_q, prev_d;
    logic pulse_q, pulse_d;
    logic rise_now;

    // Edge against previous-cycle history; next-state of both flops.
    always_comb begin
        rise_now = din & ~prev_q;
        prev_d   = din;
        pulse_d  = rise_now;
    end

    // History and registered-pulse flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign rise = REGISTERED_OUT ? pulse_q : rise_now;

endmodule

// File: rtl/flap_game_sequencer.sv
// Game-flow sequencer for the flap game: derives the frame tick from vsync,
// runs the IDLE/READY/PLAY/DYING/OVER flow, keeps score and high score,
// and turns gamepad edges into per-frame datapath commands.
module flap_game_sequencer
    import flap_game_pkg::*;
#(
    parameter int unsigned READY_FRAMES     = DEF_READY_FRAMES,
    parameter int unsigned DIE_FRAMES       = DEF_DIE_FRAMES,
    parameter int unsigned OVER_FRAMES      = DEF_OVER_FRAMES,
    parameter bit          VSYNC_ACTIVE_LOW = DEF_VSYNC_ACTIVE_LOW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       flap_btn,
    input  logic       collision,
    input  logic       pipe_passed,
    output logic       frame_tick,
    output logic       game_reset,
    output logic       run_en,
    output logic       flap_pulse,
    output logic [2:0] state,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       blink
);

    localparam logic [FRAME_CNT_W-1:0] READY_LAST = FRAME_CNT_W'(READY_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] DIE_LAST   = FRAME_CNT_W'(DIE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] OVER_LAST  = FRAME_CNT_W'(OVER_FRAMES - 1);

    logic vs_active;
    logic tick;
    logic start_rise;
    logic flap_rise;

    state_e                 state_q, state_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]             score_q, score_d;
    logic [7:0]             hs_q, hs_d;
    logic                   flap_req_q, flap_req_d;
    logic                   grst_q, grst_d;
    logic [5:0]             blink_cnt_q, blink_cnt_d;

    assign vs_active = VSYNC_ACTIVE_LOW ? ~vsync : vsync;

    // Frame tick is registered: it appears the cycle after vsync goes active.
    rise_detect #(.REGISTERED_OUT(1'b1)) u_vsync_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (vs_active),
        .rise  (tick)
    );

    rise_detect #(.REGISTERED_OUT(1'b0)) u_start_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (start_btn),
        .rise  (start_rise)
    );

    rise_detect #(.REGISTERED_OUT(1'b0)) u_flap_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (flap_btn),
        .rise  (flap_rise)
    );

    // Next-state, counters, score and flap-command logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        hs_d        = hs_q;
        flap_req_d  = flap_req_q;
        grst_d      = 1'b0;
        flap_pulse  = 1'b0;
        blink_cnt_d = blink_cnt_q + {5'd0, tick};

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_READY;
                    grst_d  = 1'b1;
                    score_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                if (tick) begin
                    if (cnt_q == READY_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (pipe_passed && (score_q != 8'hFF)) begin
                    score_d = score_q + 8'd1;
                end
                if (flap_rise) begin
                    flap_req_d = 1'b1;
                end
                if (tick) begin
                    // An edge landing on the tick cycle itself is served by this tick.
                    flap_pulse = flap_req_q | flap_rise;
                    flap_req_d = 1'b0;
                    if (collision) begin
                        state_d = ST_DYING;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DYING: begin
                if (tick) begin
                    if (cnt_q == DIE_LAST) begin
                        state_d = ST_OVER;
                        cnt_d   = '0;
                        hs_d    = max_u8(hs_q, score_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_READY;
                    grst_d  = 1'b1;
                    score_d = '0;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == OVER_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Requests never survive outside PLAY.
        if (state_d != ST_PLAY) begin
            flap_req_d = 1'b0;
        end
    end

    // State and datapath-control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            score_q     <= '0;
            hs_q        <= '0;
            flap_req_q  <= 1'b0;
            grst_q      <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            hs_q        <= hs_d;
            flap_req_q  <= flap_req_d;
            grst_q      <= grst_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign frame_tick = tick;
    assign game_reset = grst_q;
    assign run_en     = (state_q == ST_PLAY);
    assign state      = state_q;
    assign score      = score_q;
    assign high_score = hs_q;
    assign blink      = ((state_q == ST_IDLE) || (state_q == ST_OVER)) & blink_cnt_q[5];

endmodule

// File: tb/tb_flap_game_sequencer.sv
// Directed bench for flap_game_sequencer: a per-cycle vector table covering
// start, READY timing, flap coalescing, scoring and death, followed by
// hand-written sequences for OVER timeout, blink, high score, saturation,
// start-on-last-tick and asynchronous reset.
module tb_flap_game_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       start_btn;
    logic       flap_btn;
    logic       collision;
    logic       pipe_passed;
    logic       frame_tick;
    logic       game_reset;
    logic       run_en;
    logic       flap_pulse;
    logic [2:0] state;
    logic [7:0] score;
    logic [7:0] high_score;
    logic       blink;

    int checks = 0;
    int errors = 0;
    int tick_total = 0;

    flap_game_sequencer #(
        .READY_FRAMES     (4),
        .DIE_FRAMES       (3),
        .OVER_FRAMES      (10),
        .VSYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .start_btn   (start_btn),
        .flap_btn    (flap_btn),
        .collision   (collision),
        .pipe_passed (pipe_passed),
        .frame_tick  (frame_tick),
        .game_reset  (game_reset),
        .run_en      (run_en),
        .flap_pulse  (flap_pulse),
        .state       (state),
        .score       (score),
        .high_score  (high_score),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       vs, st, fl, pp, co;
        logic [2:0] e_state;
        logic [7:0] e_score;
        logic       e_run, e_tick, e_fp, e_grst;
        logic [7:0] e_hs;
    } vec_t;

    vec_t tbl[37];

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b0;
        cyc();
        vsync = 1'b1;
        cyc();
        tick_total++;
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        cyc();
    endtask

    task automatic start_game();
        press_start();
        repeat (4) frame();
    endtask

    task automatic pipes(input int n);
        repeat (n) begin
            pipe_passed = 1'b1;
            cyc();
            pipe_passed = 1'b0;
            cyc();
        end
    endtask

    task automatic crash(input logic with_pipe);
        collision = 1'b1;
        vsync = 1'b0;
        cyc();
        vsync = 1'b1;
        pipe_passed = with_pipe;
        cyc();
        pipe_passed = 1'b0;
        collision = 1'b0;
        tick_total++;
    endtask

    initial begin
        //           vs    st    fl    pp    co    state score run  tick fp   grst hs
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[26] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[27] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[28] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[29] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[30] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[31] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[32] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[33] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[34] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[35] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[36] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};

        rst_n = 1'b0;
        vsync = 1'b1;
        start_btn = 1'b0;
        flap_btn = 1'b0;
        collision = 1'b0;
        pipe_passed = 1'b0;

        // Reset state while held in reset.
        #12;
        chk("rst_state", -1, 32'(state), 32'd0);
        chk("rst_outs", -1, {frame_tick, game_reset, run_en, flap_pulse, blink}, 32'd0);
        chk("rst_scores", -1, {score, high_score}, 32'd0);
        #10;
        rst_n = 1'b1;
        cyc();

        // Per-cycle vector table.
        for (int i = 0; i < 37; i++) begin
            vsync       = tbl[i].vs;
            start_btn   = tbl[i].st;
            flap_btn    = tbl[i].fl;
            pipe_passed = tbl[i].pp;
            collision   = tbl[i].co;
            @(negedge clk);
            chk("state", i, 32'(state), 32'(tbl[i].e_state));
            chk("score", i, 32'(score), 32'(tbl[i].e_score));
            chk("run_en", i, 32'(run_en), 32'(tbl[i].e_run));
            chk("frame_tick", i, 32'(frame_tick), 32'(tbl[i].e_tick));
            chk("flap_pulse", i, 32'(flap_pulse), 32'(tbl[i].e_fp));
            chk("game_reset", i, 32'(game_reset), 32'(tbl[i].e_grst));
            chk("high_score", i, 32'(high_score), 32'(tbl[i].e_hs));
            chk("blink", i, 32'(blink), 32'd0);
            if (tbl[i].e_tick) tick_total++;
            cyc();
        end
        vsync = 1'b1;
        start_btn = 1'b0;
        flap_btn = 1'b0;
        pipe_passed = 1'b0;
        collision = 1'b0;

        // OVER times out to IDLE after exactly 10 ticks; blink tracks tick count.
        for (int i = 1; i <= 10; i++) begin
            frame();
            chk("over_timeout_state", i, 32'(state), (i == 10) ? 32'd0 : 32'd4);
            chk("over_blink", i, 32'(blink), 32'((tick_total >> 5) & 1));
        end
        for (int i = 0; i < 20; i++) begin
            frame();
            chk("idle_blink", i, 32'(blink), 32'((tick_total >> 5) & 1));
        end
        chk("idle_blink_high", -1, 32'(blink), 32'd1);

        // Game 2: score 7, crash with a simultaneous pipe -> 8, high score 8.
        start_game();
        chk("g2_play", -1, {29'd0, state}, 32'd2);
        chk("g2_run_en", -1, 32'(run_en), 32'd1);
        chk("g2_blink_play", -1, 32'(blink), 32'd0);
        pipes(7);
        chk("g2_score7", -1, 32'(score), 32'd7);
        crash(1'b1);
        chk("g2_dying", -1, 32'(state), 32'd3);
        chk("g2_score8", -1, 32'(score), 32'd8);
        chk("g2_hs_pre", -1, 32'(high_score), 32'd4);
        repeat (3) frame();
        chk("g2_over", -1, 32'(state), 32'd4);
        chk("g2_hs", -1, 32'(high_score), 32'd8);

        // Game 3: start from OVER, end at 5, high score stays 8.
        press_start();
        chk("g3_ready", -1, 32'(state), 32'd1);
        chk("g3_score_clr", -1, 32'(score), 32'd0);
        repeat (4) frame();
        pipes(5);
        crash(1'b0);
        chk("g3_dying_score", -1, 32'(score), 32'd5);
        repeat (3) frame();
        chk("g3_over", -1, 32'(state), 32'd4);
        chk("g3_hs_kept", -1, 32'(high_score), 32'd8);

        // Game 4: score saturates at 255.
        start_game();
        pipes(254);
        chk("g4_score254", -1, 32'(score), 32'd254);
        pipes(46);
        chk("g4_score_sat", -1, 32'(score), 32'd255);
        crash(1'b1);
        chk("g4_score_sat_crash", -1, 32'(score), 32'd255);
        repeat (3) frame();
        chk("g4_hs", -1, 32'(high_score), 32'd255);

        // Start edge coincident with the final OVER tick goes to READY.
        repeat (9) frame();
        chk("over9_state", -1, 32'(state), 32'd4);
        vsync = 1'b0;
        cyc();
        vsync = 1'b1;
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        tick_total++;
        chk("start_wins_state", -1, 32'(state), 32'd1);
        chk("start_wins_grst", -1, 32'(game_reset), 32'd1);
        chk("start_wins_score", -1, 32'(score), 32'd0);
        cyc();
        chk("grst_single", -1, 32'(game_reset), 32'd0);

        // Asynchronous reset in the middle of a game with score 12.
        repeat (4) frame();
        pipes(12);
        chk("g5_score12", -1, 32'(score), 32'd12);
        chk("g5_run_en", -1, 32'(run_en), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_state", -1, 32'(state), 32'd0);
        chk("arst_score", -1, 32'(score), 32'd0);
        chk("arst_hs", -1, 32'(high_score), 32'd0);
        chk("arst_outs", -1, {frame_tick, game_reset, run_en, flap_pulse, blink}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_state", -1, 32'(state), 32'd0);
        chk("post_rst_hs", -1, 32'(high_score), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
